// File: rtl/raabb_cmp_pkg.sv
// Shared types and constants for the slab compare sequencer: FP exception
// codes, subtractor op ids, FSM state encoding, op tag and the FP zero word.
package raabb_cmp_pkg;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_t;

    typedef enum logic [2:0] {
        OP_C0 = 3'd0,
        OP_C1 = 3'd1,
        OP_C2 = 3'd2,
        OP_C3 = 3'd3,
        OP_C4 = 3'd4,
        OP_C5 = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        P1,
        W1,
        P2,
        W2,
        P3,
        W3,
        DONE
    } state_t;

    typedef struct packed {
        logic valid;
        op_t  op;
    } tag_t;

    // Zero is all bits clear (exception field EXC_ZERO); sliced to the word width by users.
    localparam int unsigned         FP_MAX_W = 64;
    localparam logic [FP_MAX_W-1:0] FP_ZERO  = '0;

endpackage

// File: rtl/fp_ge_decode.sv
// Combinational decode of a subtractor result R = X-Y into X >= Y.
module fp_ge_decode
    import raabb_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 26
) (
    input  logic [WIDTH:0] r,
    output logic           ge
);

    exc_t exc;
    logic sgn;
    logic unused_mag;

    assign exc        = exc_t'(r[WIDTH:WIDTH-1]);
    assign sgn        = r[WIDTH-2];
    assign unused_mag = ^r[WIDTH-3:0];

    // Zero difference is GE, finite/infinite follow the sign, NaN is never GE.
    always_comb begin
        ge = 1'b0;
        case (exc)
            EXC_ZERO:            ge = 1'b1;
            EXC_NORMAL, EXC_INF: ge = !sgn;
            default:             ge = 1'b0;
        endcase
    end

endmodule

// File: rtl/slab_compare_sequencer.sv
// Ray/AABB slab reduction sequenced over one shared external pipelined FP
// subtractor: tmin = max(tnear), tmax = min(tfar), hit = tmax >= tmin.
// Optional macro RAABB_ORIGIN_CLIP_EN adds a tmax >= 0 test to hit.
module slab_compare_sequencer
    import raabb_cmp_pkg::*;
#(
    parameter int unsigned WIDTH   = 26,
    parameter int unsigned SUB_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIDTH:0] tnear_x,
    input  logic [WIDTH:0] tnear_y,
    input  logic [WIDTH:0] tnear_z,
    input  logic [WIDTH:0] tfar_x,
    input  logic [WIDTH:0] tfar_y,
    input  logic [WIDTH:0] tfar_z,
    output logic [WIDTH:0] cmp_a,
    output logic [WIDTH:0] cmp_b,
    output logic           cmp_issue,
    input  logic [WIDTH:0] cmp_r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           hit,
    output logic [WIDTH:0] tmin_out,
    output logic [WIDTH:0] tmax_out
);

    state_t         state, state_nxt;
    logic           step, step_nxt;
    logic           ready_en;
    logic           issue;
    op_t            issue_op;
    logic [WIDTH:0] a_sel, b_sel, a_last, b_last;
    logic [WIDTH:0] tnx, tny, tnz, tfx, tfy, tfz;
    logic [WIDTH:0] nmax, fmin, tmin, tmax;
    logic           ge, ge_hit;
    op_t            exp_op;
    tag_t           tag_pipe [SUB_LAT];
    tag_t           tag_out;
`ifdef RAABB_ORIGIN_CLIP_EN
    logic           ge_pos;
`endif

    fp_ge_decode #(.WIDTH(WIDTH)) u_ge (
        .r  (cmp_r),
        .ge (ge)
    );

    assign tag_out   = tag_pipe[SUB_LAT-1];
    assign in_ready  = ready_en && (state == IDLE);
    assign out_valid = (state == DONE);
    assign cmp_issue = issue;
    assign cmp_a     = issue ? a_sel : a_last;
    assign cmp_b     = issue ? b_sel : b_last;
    assign tmin_out  = tmin;
    assign tmax_out  = tmax;
`ifdef RAABB_ORIGIN_CLIP_EN
    assign hit = ge_hit && ge_pos;
`else
    assign hit = ge_hit;
`endif

    // State register; ready_en keeps in_ready low until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            step     <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            ready_en <= 1'b1;
        end
    end

    // Next state and subtractor issue; step selects the op within a P phase.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        issue     = 1'b0;
        issue_op  = OP_C0;
        a_sel     = '0;
        b_sel     = '0;
        case (state)
            IDLE: begin
                step_nxt = 1'b0;
                if (in_valid && in_ready) state_nxt = P1;
            end
            P1: begin
                issue = 1'b1;
                if (!step) begin
                    issue_op = OP_C0; a_sel = tnx; b_sel = tny; step_nxt = 1'b1;
                end else begin
                    issue_op = OP_C1; a_sel = tfx; b_sel = tfy; step_nxt = 1'b0;
                    state_nxt = W1;
                end
            end
            W1: if (tag_out.valid && tag_out.op == OP_C1) state_nxt = P2;
            P2: begin
                issue = 1'b1;
                if (!step) begin
                    issue_op = OP_C2; a_sel = nmax; b_sel = tnz; step_nxt = 1'b1;
                end else begin
                    issue_op = OP_C3; a_sel = fmin; b_sel = tfz; step_nxt = 1'b0;
                    state_nxt = W2;
                end
            end
            W2: if (tag_out.valid && tag_out.op == OP_C3) state_nxt = P3;
            P3: begin
                issue = 1'b1;
`ifdef RAABB_ORIGIN_CLIP_EN
                if (!step) begin
                    issue_op = OP_C4; a_sel = tmax; b_sel = tmin; step_nxt = 1'b1;
                end else begin
                    issue_op = OP_C5; a_sel = tmax; b_sel = FP_ZERO[WIDTH:0]; step_nxt = 1'b0;
                    state_nxt = W3;
                end
`else
                issue_op = OP_C4; a_sel = tmax; b_sel = tmin;
                state_nxt = W3;
`endif
            end
            W3: begin
`ifdef RAABB_ORIGIN_CLIP_EN
                if (tag_out.valid && tag_out.op == OP_C5) state_nxt = DONE;
`else
                if (tag_out.valid && tag_out.op == OP_C4) state_nxt = DONE;
`endif
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Hold the last driven operands so cmp_a/cmp_b stay put between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_last <= '0;
            b_last <= '0;
        end else begin
            a_last <= cmp_a;
            b_last <= cmp_b;
        end
    end

    // Tag shift register: slot SUB_LAT-1 describes the cmp_r present this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SUB_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: issue, op: issue_op};
            for (int unsigned i = 1; i < SUB_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Operand capture on acceptance and result consumption by tagged op id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tnx <= '0; tny <= '0; tnz <= '0;
            tfx <= '0; tfy <= '0; tfz <= '0;
            nmax <= '0; fmin <= '0; tmin <= '0; tmax <= '0;
            ge_hit <= 1'b0;
            exp_op <= OP_C0;
`ifdef RAABB_ORIGIN_CLIP_EN
            ge_pos <= 1'b0;
`endif
        end else begin
            if (in_valid && in_ready) begin
                tnx <= tnear_x; tny <= tnear_y; tnz <= tnear_z;
                tfx <= tfar_x;  tfy <= tfar_y;  tfz <= tfar_z;
                exp_op <= OP_C0;
            end
            if (tag_out.valid) begin
                exp_op <= op_t'(3'(exp_op) + 3'd1);
                case (tag_out.op)
                    OP_C0: nmax   <= ge ? tnx  : tny;
                    OP_C1: fmin   <= ge ? tfy  : tfx;
                    OP_C2: tmin   <= ge ? nmax : tnz;
                    OP_C3: tmax   <= ge ? tfz  : fmin;
                    OP_C4: ge_hit <= ge;
`ifdef RAABB_ORIGIN_CLIP_EN
                    OP_C5: ge_pos <= ge;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Results must come back in issue order.
    tag_order: assert property (@(posedge clk) disable iff (rst)
        tag_out.valid |-> (tag_out.op == exp_op));

endmodule

// File: doc/slab_compare_sequencer.md
Name: slab_compare_sequencer

Overview:
- Sequences the ray/AABB slab reduction over one shared pipelined FP subtractor (FloPoCo 11_13 format, fixed latency).
- Takes per-axis entry/exit distances (tnear_x/y/z, tfar_x/y/z) and computes:
  - tmin = max(tnear)
  - tmax = min(tfar)
  - hit = (tmax >= tmin) and, optionally, (tmax >= 0).
- Drives the external subtractor through its operand/result ports and keeps in-flight operations tagged.

Parameters:
- WIDTH, 26, MSB index of an FP word. Word layout [WIDTH:0]: exception bits [WIDTH:WIDTH-1], sign [WIDTH-2], then exponent and mantissa.
- SUB_LAT, 2, subtractor pipeline latency in cycles (>=1). cmp_r in cycle k+SUB_LAT belongs to the operands driven in cycle k.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept an operand set
- tnear_x, tnear_y, tnear_z  in  WIDTH+1 each  slab entry distances
- tfar_x, tfar_y, tfar_z  in  WIDTH+1 each  slab exit distances
- cmp_a  out  WIDTH+1  subtractor X operand
- cmp_b  out  WIDTH+1  subtractor Y operand
- cmp_issue  out  1  cmp_a/cmp_b carry a live operation this cycle
- cmp_r  in  WIDTH+1  subtractor result R = X-Y
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- hit  out  1  ray intersects box
- tmin_out  out  WIDTH+1  max of tnear
- tmax_out  out  WIDTH+1  min of tfar

Behaviour:
- Clock and reset:
  - Single clock clk. rst is asynchronous and active-high; it clears all state immediately.
  - Reset values: in_ready=0 while rst is asserted and 1 in the first cycle after it falls. out_valid=0, hit=0, cmp_issue=0, and cmp_a, cmp_b, tmin_out, tmax_out = 0.
- GE decode of cmp_r (X>=Y), using exc = R[WIDTH:WIDTH-1] and s = R[WIDTH-2]:
  - exc=00 (zero) -> 1
  - exc=01 or exc=10 -> !s
  - exc=11 (NaN) -> 0
- Input handshake:
  - Transfer occurs when in_valid && in_ready. in_ready=1 only in IDLE.
  - The six inputs are captured into local registers on acceptance.
- FSM states: IDLE, P1, W1, P2, W2, P3, W3, DONE. Each Pn issues on consecutive cycles; each Wn waits for the last result of its phase.
- Timing: acceptance is cycle 0. Each op's result is registered at the end of its result cycle.
- Operation schedule, L=SUB_LAT:
  - C0: tnear_x - tnear_y, issued cycle 1. GE -> nmax = tnear_x, else tnear_y. Tie picks tnear_x.
  - C1: tfar_x - tfar_y, issued cycle 2. GE -> fmin = tfar_y, else tfar_x.
  - C2: nmax - tnear_z, issued cycle L+3. GE -> tmin = nmax, else tnear_z.
  - C3: fmin - tfar_z, issued cycle L+4. GE -> tmax = tfar_z, else fmin.
  - C4: tmax - tmin, issued cycle 2L+5. Result ge_hit.
  - C5 (macro only): tmax - 0, issued cycle 2L+6. Result ge_pos.
- Result output:
  - out_valid asserted in cycle 3L+7 (macro defined) or 3L+6 (macro undefined). With L=2: cycle 13 or 12.
  - hit, tmin_out and tmax_out stay stable while out_valid=1.
  - A transfer happens in any cycle with out_valid && out_ready, including the first. The FSM then goes to IDLE and in_ready=1 the next cycle.
- cmp_issue=1 exactly in the issue cycles. Otherwise cmp_a and cmp_b hold their last values.
- Tag shift register, SUB_LAT deep, 3-bit op id plus valid bit:
  - Results are consumed only when the tag is valid.
  - A result whose op id does not match the expected op id is a design error (assertion).
- Boundary conditions:
  - Reset mid-operation: tag pipe cleared, any in-flight results ignored, FSM returns to IDLE.
  - Back-to-back requests are not overlapped; throughput is one request per (latency + 1) cycles minimum.
  - out_ready held low: DONE holds indefinitely and in_ready stays 0.
  - Any NaN operand yields GE=0 at that step. The selection rules above then apply unchanged.

Optional Feature:
- RAABB_ORIGIN_CLIP_EN defined: P3 issues C4 and C5, and hit = ge_hit && ge_pos. A box entirely behind the origin misses.
- Undefined: P3 issues only C4, hit = ge_hit, and latency shrinks by one cycle.

Decomposition:
- Package raabb_cmp_pkg:
  - exception codes EXC_ZERO/NORMAL/INF/NAN
  - op ids OP_C0..OP_C5
  - FSM state encoding
  - FP zero constant
- Sub-module fp_ge_decode: combinational cmp_r -> ge, used by the sequencer.

Test Plan:
- Ordered inputs, L=2:
  - Stimulus: tnear={1.0,2.0,0.5}, tfar={5.0,3.0,4.0}.
  - Response: out_valid at cycle 13, tmin_out=2.0, tmax_out=3.0, hit=1.
  - Also check cmp_issue pulses at cycles 1, 2, 5, 6, 9, 10.
- Disjoint slabs:
  - Stimulus: tnear={4.0,1.0,1.0}, tfar={5.0,3.0,6.0}.
  - Response: tmin=4.0, tmax=3.0, hit=0.
- Ties:
  - Stimulus: tnear all 2.0, tfar all 2.0.
  - Response: tmin=tmax=2.0, hit=1 (zero result decodes GE=1).
- Behind origin, macro on:
  - Stimulus: tnear={-5,-4,-6}, tfar={-1,-2,-3}.
  - Response: tmin=-4, tmax=-3, hit=0. With the macro off: hit=1 at cycle 12.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles: out_valid and all result fields stay stable, in_ready=0.
  - Assert rst in cycle 4 of a new operation: outputs return to reset values immediately, in_ready=1 one cycle after rst falls, and no spurious out_valid.
